// File: rtl/fdct_pkg.sv
// Shared FDCT constants: default coefficient format and the Loeffler rotation
// triplets, expressed for y0 = A*(x0+x1) + BMA*x1, y1 = A*(x0+x1) + NAPB*x0.
package fdct_pkg;

    localparam int COEF_W_DEF    = 12;
    localparam int COEF_FRAC_DEF = 10;

    typedef logic signed [COEF_W_DEF-1:0] coef_t;

    typedef struct packed {
        coef_t a;
        coef_t bma;
        coef_t napb;
    } rot_coef_t;

    // Rotation y0 = c*x0 + s*x1, y1 = -s*x0 + c*x1 with A = c, BMA = s-c, NAPB = -s-c.
    localparam rot_coef_t C1 = '{a: 12'sd1004, bma: -12'sd804, napb: -12'sd1204};
    localparam rot_coef_t C3 = '{a: 12'sd851,  bma: -12'sd282, napb: -12'sd1420};
    localparam rot_coef_t C6 = '{a: 12'sd392,  bma: 12'sd554,  napb: -12'sd1338};

endpackage

// File: rtl/round_sat.sv
// Combinational arithmetic right shift with optional round-half-up, followed by
// saturation of the signed result to OUT_W bits with a clip flag.
module round_sat #(
    parameter int IN_W  = 22,
    parameter int OUT_W = 10,
    parameter int SHIFT = 10,
    parameter int ROUND = 1
) (
    input  logic [IN_W-1:0]  din,
    output logic [OUT_W-1:0] dout,
    output logic             clip
);

    localparam int HS = (SHIFT > 0) ? SHIFT - 1 : 0;
    localparam logic signed [IN_W-1:0] HALF =
        (ROUND != 0 && SHIFT > 0) ? (IN_W'(1) << HS) : '0;
    localparam logic signed [IN_W-1:0] MAXV = IN_W'((longint'(1) << (OUT_W-1)) - 1);
    localparam logic signed [IN_W-1:0] MINV = -MAXV - IN_W'(1);

    function automatic logic [OUT_W:0] round_sat_f(input logic signed [IN_W-1:0] v);
        logic signed [IN_W-1:0] s;
        s = (v + HALF) >>> SHIFT;
        if (s > MAXV)
            return {1'b1, MAXV[OUT_W-1:0]};
        else if (s < MINV)
            return {1'b1, MINV[OUT_W-1:0]};
        else
            return {1'b0, s[OUT_W-1:0]};
    endfunction

    assign {clip, dout} = round_sat_f(din);

endmodule

// File: rtl/rotation_pipe.sv
// Three-stage pipelined Loeffler rotation with valid/ready flow control and
// per-stage bubble collapse; outputs are rounded and saturated to OUT_W bits.
module rotation_pipe
    import fdct_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int COEF_W    = COEF_W_DEF,
    parameter int COEF_FRAC = COEF_FRAC_DEF,
    parameter int OUT_W     = 10,
    parameter logic signed [COEF_W-1:0] A    = '0,
    parameter logic signed [COEF_W-1:0] BMA  = '0,
    parameter logic signed [COEF_W-1:0] NAPB = '0,
    parameter int ROUND     = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x0,
    input  logic [WIDTH-1:0] x1,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] y0,
    output logic [OUT_W-1:0] y1,
    output logic             sat
);

    localparam int SW = WIDTH + 1;
    localparam int PW = WIDTH + 1 + COEF_W;
    localparam int TW = WIDTH + 2 + COEF_W;

    logic vld_p1, vld_p2, vld_p3;
    logic en1, en2, en3;

    logic signed [SW-1:0] x0_ext, x1_ext;
    logic signed [SW-1:0] x0_p1, x1_p1, sum_p1;
    logic signed [PW-1:0] p0_p2, p1_p2, p2_p2;
    logic signed [TW-1:0] t0, t1;
    logic [OUT_W-1:0]     y0_rs, y1_rs;
    logic                 clip0, clip1;
    logic [OUT_W-1:0]     y0_p3, y1_p3;
    logic                 sat_p3;

    // A stage may load when it is empty or the stage after it is moving.
    assign en3      = !vld_p3 || out_ready;
    assign en2      = !vld_p2 || en3;
    assign en1      = !vld_p1 || en2;
    assign in_ready = en1;

    assign x0_ext = {x0[WIDTH-1], x0};
    assign x1_ext = {x1[WIDTH-1], x1};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
            vld_p3 <= 1'b0;
            y0_p3  <= '0;
            y1_p3  <= '0;
            sat_p3 <= 1'b0;
        end else begin
            if (en1) vld_p1 <= in_valid;
            if (en2) vld_p2 <= vld_p1;
            if (en3) begin
                vld_p3 <= vld_p2;
                if (vld_p2) begin
                    y0_p3  <= y0_rs;
                    y1_p3  <= y1_rs;
                    sat_p3 <= clip0 | clip1;
                end
            end
        end
    end

    // S1: sign-extended operands and their exact sum
    always_ff @(posedge clk) begin
        if (en1) begin
            x0_p1  <= x0_ext;
            x1_p1  <= x1_ext;
            sum_p1 <= x0_ext + x1_ext;
        end
    end

    // S2: exact products
    always_ff @(posedge clk) begin
        if (en2) begin
            p0_p2 <= PW'(x1_p1) * PW'(BMA);
            p1_p2 <= PW'(x0_p1) * PW'(NAPB);
            p2_p2 <= PW'(sum_p1) * PW'(A);
        end
    end

    // S3: full-width sums, then scale/round/saturate into the output register
    assign t0 = TW'(p0_p2) + TW'(p2_p2);
    assign t1 = TW'(p1_p2) + TW'(p2_p2);

    round_sat #(.IN_W(TW), .OUT_W(OUT_W), .SHIFT(COEF_FRAC), .ROUND(ROUND)) u_rs0 (
        .din  (t0),
        .dout (y0_rs),
        .clip (clip0)
    );

    round_sat #(.IN_W(TW), .OUT_W(OUT_W), .SHIFT(COEF_FRAC), .ROUND(ROUND)) u_rs1 (
        .din  (t1),
        .dout (y1_rs),
        .clip (clip1)
    );

    assign out_valid = vld_p3;
    assign y0        = y0_p3;
    assign y1        = y1_p3;
    assign sat       = sat_p3;

endmodule

// File: tb/tb_rotation_pipe.sv
// Bench for rotation_pipe: five parameterisations share one input stream and
// are checked against an arithmetic reference of the rotation equations.
module tb_rotation_pipe;
    import fdct_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b0;
    logic [7:0] x0 = '0;
    logic [7:0] x1 = '0;

    logic [4:0] rdy, ov, st;
    logic [9:0] y0_id, y1_id, y0_r1, y1_r1, y0_r0, y1_r0, y0_c6, y1_c6;
    logic [7:0] y0_st, y1_st;

    int checks = 0;
    int failures = 0;

    longint cA[5], cB[5], cN[5];
    int     cR[5], cO[5];

    always #5 clk = ~clk;

    rotation_pipe #(.WIDTH(8), .COEF_W(12), .COEF_FRAC(10), .OUT_W(10),
        .A(12'sd1024), .BMA(12'sd0), .NAPB(12'sd0), .ROUND(1)) u_id (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[0]),
        .x0(x0), .x1(x1), .out_valid(ov[0]), .out_ready(out_ready),
        .y0(y0_id), .y1(y1_id), .sat(st[0]));

    rotation_pipe #(.WIDTH(8), .COEF_W(12), .COEF_FRAC(10), .OUT_W(10),
        .A(12'sd512), .BMA(12'sd0), .NAPB(12'sd0), .ROUND(1)) u_r1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[1]),
        .x0(x0), .x1(x1), .out_valid(ov[1]), .out_ready(out_ready),
        .y0(y0_r1), .y1(y1_r1), .sat(st[1]));

    rotation_pipe #(.WIDTH(8), .COEF_W(12), .COEF_FRAC(10), .OUT_W(10),
        .A(12'sd512), .BMA(12'sd0), .NAPB(12'sd0), .ROUND(0)) u_r0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[2]),
        .x0(x0), .x1(x1), .out_valid(ov[2]), .out_ready(out_ready),
        .y0(y0_r0), .y1(y1_r0), .sat(st[2]));

    rotation_pipe #(.WIDTH(8), .COEF_W(12), .COEF_FRAC(10), .OUT_W(8),
        .A(12'sd1024), .BMA(12'sd0), .NAPB(12'sd0), .ROUND(1)) u_st (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[3]),
        .x0(x0), .x1(x1), .out_valid(ov[3]), .out_ready(out_ready),
        .y0(y0_st), .y1(y1_st), .sat(st[3]));

    rotation_pipe #(.WIDTH(8), .COEF_W(12), .COEF_FRAC(10), .OUT_W(10),
        .A(C6.a), .BMA(C6.bma), .NAPB(C6.napb), .ROUND(1)) u_c6 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[4]),
        .x0(x0), .x1(x1), .out_valid(ov[4]), .out_ready(out_ready),
        .y0(y0_c6), .y1(y1_c6), .sat(st[4]));

    task automatic chk(input string tag, input longint obs, input longint exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Scale by 2^-10 with floor division, optional +0.5 first, then clamp.
    function automatic longint model_scale(input longint t, input int rnd, input int ow,
                                           output bit clip);
        longint v, q, hi, lo;
        v  = t + (rnd != 0 ? 512 : 0);
        q  = v / 1024;
        if ((v % 1024) != 0 && v < 0) q = q - 1;
        hi = (longint'(1) << (ow - 1)) - 1;
        lo = -hi - 1;
        clip = 1'b0;
        if (q > hi) begin q = hi; clip = 1'b1; end
        if (q < lo) begin q = lo; clip = 1'b1; end
        return q;
    endfunction

    function automatic longint obs_y(input int i, input int which);
        case (i)
            0: return which != 0 ? longint'($signed(y1_id)) : longint'($signed(y0_id));
            1: return which != 0 ? longint'($signed(y1_r1)) : longint'($signed(y0_r1));
            2: return which != 0 ? longint'($signed(y1_r0)) : longint'($signed(y0_r0));
            3: return which != 0 ? longint'($signed(y1_st)) : longint'($signed(y0_st));
            default: return which != 0 ? longint'($signed(y1_c6)) : longint'($signed(y0_c6));
        endcase
    endfunction

    task automatic chk_all(input string tag, input longint xa, input longint xb);
        longint e0, e1, base;
        bit c0, c1;
        for (int i = 0; i < 5; i++) begin
            base = cA[i] * (xa + xb);
            e0 = model_scale(base + cB[i] * xb, cR[i], cO[i], c0);
            e1 = model_scale(base + cN[i] * xa, cR[i], cO[i], c1);
            chk($sformatf("%s_u%0d_ov", tag, i), ov[i], 1);
            chk($sformatf("%s_u%0d_y0", tag, i), obs_y(i, 0), e0);
            chk($sformatf("%s_u%0d_y1", tag, i), obs_y(i, 1), e1);
            chk($sformatf("%s_u%0d_sat", tag, i), st[i], c0 | c1);
        end
    endtask

    // One sample through an idle pipeline; returns with its output on the port.
    task automatic single(input string tag, input longint xa, input longint xb);
        @(negedge clk);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        x0 = xa[7:0];
        x1 = xb[7:0];
        #1 chk({tag, "_acc_rdy"}, rdy, 5'h1f);
        @(negedge clk);
        in_valid = 1'b0;
        #1 chk({tag, "_lat1"}, ov, 0);
        @(negedge clk);
        #1 chk({tag, "_lat2"}, ov, 0);
        @(negedge clk);
        #1 chk({tag, "_lat3"}, ov, 5'h1f);
        chk_all(tag, xa, xb);
    endtask

    longint qa[$], qb[$];
    longint bx0[4], bx1[4];
    longint pa, pb, snap, prev_snap;
    bit     held;
    int     sent, got, cyc, k;

    initial begin
        cA = '{1024, 512, 512, 1024, longint'($signed(C6.a))};
        cB = '{0, 0, 0, 0, longint'($signed(C6.bma))};
        cN = '{0, 0, 0, 0, longint'($signed(C6.napb))};
        cR = '{1, 1, 0, 1, 1};
        cO = '{10, 10, 10, 8, 10};

        repeat (3) @(negedge clk);
        #1;
        chk("rst_ov", ov, 0);
        chk("rst_sat", st, 0);
        chk("rst_y_c6", {y0_c6, y1_c6}, 0);
        chk("rst_y_st", {y0_st, y1_st}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("rst_rdy", rdy, 5'h1f);

        single("ident", 100, 27);
        chk("ident_y0", $signed(y0_id), 127);
        chk("ident_y1", $signed(y1_id), 127);
        chk("ident_sat", st[0], 0);

        single("rnd_p1", 1, 0);
        chk("r1_p1_y0", $signed(y0_r1), 1);
        chk("r1_p1_y1", $signed(y1_r1), 1);
        chk("r0_p1_y0", $signed(y0_r0), 0);
        chk("r0_p1_y1", $signed(y1_r0), 0);

        single("rnd_m1", -1, 0);
        chk("r1_m1_y0", $signed(y0_r1), 0);
        chk("r1_m1_y1", $signed(y1_r1), 0);
        chk("r0_m1_y0", $signed(y0_r0), -1);
        chk("r0_m1_y1", $signed(y1_r0), -1);

        single("sat_hi", 127, 127);
        chk("sat_hi_y0", $signed(y0_st), 127);
        chk("sat_hi_y1", $signed(y1_st), 127);
        chk("sat_hi_flag", st[3], 1);

        single("sat_lo", -128, -128);
        chk("sat_lo_y0", $signed(y0_st), -128);
        chk("sat_lo_y1", $signed(y1_st), -128);
        chk("sat_lo_flag", st[3], 1);

        single("sat_mid", 10, 5);
        chk("sat_mid_y0", $signed(y0_st), 15);
        chk("sat_mid_y1", $signed(y1_st), 15);
        chk("sat_mid_flag", st[3], 0);

        // Back-pressure: four offered with out_ready low, three fit.
        for (int i = 0; i < 4; i++) begin
            bx0[i] = longint'($urandom_range(0, 255)) - 128;
            bx1[i] = longint'($urandom_range(0, 255)) - 128;
        end
        @(negedge clk);
        out_ready = 1'b0;
        k = 0;
        for (int c = 0; c < 4; c++) begin
            in_valid = 1'b1;
            x0 = bx0[k][7:0];
            x1 = bx1[k][7:0];
            #1 chk($sformatf("bp_rdy_%0d", c), rdy, (c < 3) ? 5'h1f : 5'h00);
            if (rdy[4]) k++;
            @(negedge clk);
        end
        chk("bp_accepted", k, 3);
        out_ready = 1'b1;
        #1;
        chk("bp_release_rdy", rdy, 5'h1f);
        chk_all("bp_s0", bx0[0], bx1[0]);
        @(negedge clk);
        in_valid = 1'b0;
        for (int j = 1; j < 4; j++) begin
            #1 chk_all($sformatf("bp_s%0d", j), bx0[j], bx1[j]);
            @(negedge clk);
        end
        #1 chk("bp_empty", ov, 0);

        // Asynchronous reset with two samples in flight.
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        x0 = 8'd50;
        x1 = 8'd60;
        @(negedge clk);
        x0 = 8'hba;
        x1 = 8'd33;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        #1 chk("mid_ov_before", ov[4], 1);
        chk_all("mid_s0", 50, 60);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_ov", ov, 0);
        chk("mid_rst_sat", st, 0);
        chk("mid_rst_y_c6", {y0_c6, y1_c6}, 0);
        chk("mid_rst_y_id", {y0_id, y1_id}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int j = 0; j < 6; j++) begin
            #1 chk($sformatf("post_rst_ov_%0d", j), ov, 0);
            @(negedge clk);
        end

        // Random stream with random valid and ready.
        sent = 0;
        got  = 0;
        cyc  = 0;
        held = 1'b0;
        prev_snap = 0;
        while (got < 1000 && cyc < 20000) begin
            in_valid  = (sent < 1000) && ($urandom_range(0, 9) < 7);
            x0        = 8'($urandom);
            x1        = 8'($urandom);
            out_ready = ($urandom_range(0, 9) < 7);
            #1;
            snap = longint'({y0_c6, y1_c6, y0_st, y1_st, st});
            if (held) begin
                chk("hold_ov", ov, 5'h1f);
                chk("hold_outputs", snap, prev_snap);
            end
            held = ov[4] && !out_ready;
            prev_snap = snap;
            if (ov[4] && out_ready) begin
                if (qa.size() == 0) begin
                    chk("rnd_spurious_output", 1, 0);
                end else begin
                    pa = qa.pop_front();
                    pb = qb.pop_front();
                    chk_all("rnd", pa, pb);
                end
                got++;
            end
            if (in_valid && rdy[4]) begin
                qa.push_back(longint'($signed(x0)));
                qb.push_back(longint'($signed(x1)));
                sent++;
            end
            @(negedge clk);
            cyc++;
        end
        in_valid = 1'b0;
        chk("rnd_outputs", got, 1000);
        chk("rnd_inputs", sent, 1000);
        chk("rnd_queue_empty", qa.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
